// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and load/store.
// Data requests normally win arbitration. A starvation counter forces a fetch through
// after STARVE_MAX consecutive data wins taken while fetch was waiting. Only one memory
// transaction is outstanding at a time. Read data is returned to the transaction owner.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   if_req/if_addr                  fetch read request
//   if_gnt/if_rvalid/if_rdata       fetch grant and read response
//   d_req/d_we/d_be/d_addr/d_wdata  load/store request
//   d_gnt/d_rvalid/d_rdata          data grant and load response
//   mem_req/we/be/addr/wdata        memory request, held stable until mem_gnt
//   mem_gnt/mem_rvalid/mem_rdata    memory handshake and read data
//   owner                           0 = fetch, 1 = data; 0 while idle
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                owner
);

  localparam int unsigned BeW  = DATA_W / 8;
  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [BeW-1:0]    be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              owner_q, owner_d;

  logic fetch_win;
  logic data_win;
  logic issue;
  logic rsp;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    addr_d       = addr_q;
    we_d         = we_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    owner_d      = owner_q;
    if_gnt       = 1'b0;
    d_gnt        = 1'b0;

    fetch_win = if_req && (!d_req || (starve_cnt_q == CntMax));
    data_win  = d_req && !fetch_win;

    unique case (state_q)
      StIdle: begin
        // Grants are combinational; gate with rst_n so they drop the moment reset asserts.
        if (rst_n) begin
          if (fetch_win) begin
            if_gnt       = 1'b1;
            addr_d       = if_addr;
            we_d         = 1'b0;
            be_d         = '1;
            wdata_d      = '0;
            owner_d      = 1'b0;
            starve_cnt_d = '0;
            state_d      = StIssue;
          end else if (data_win) begin
            d_gnt   = 1'b1;
            addr_d  = d_addr;
            we_d    = d_we;
            be_d    = d_be;
            wdata_d = d_wdata;
            owner_d = 1'b1;
            // Only count wins that actually made fetch wait.
            if (if_req && (starve_cnt_q != CntMax)) begin
              starve_cnt_d = starve_cnt_q + CntW'(1);
            end
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (mem_gnt) begin
          state_d = we_q ? StIdle : StWait;
        end
      end
      StWait: begin
        if (mem_rvalid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      owner_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      owner_q      <= owner_d;
    end
  end

  // Memory fields are only driven while the request is presented.
  always_comb begin
    issue     = (state_q == StIssue);
    mem_req   = issue;
    mem_we    = issue & we_q;
    mem_be    = issue ? be_q : '0;
    mem_addr  = issue ? addr_q : '0;
    mem_wdata = issue ? wdata_q : '0;
    owner     = (state_q != StIdle) & owner_q;

    // Responses outside WAIT are stray and dropped.
    rsp       = (state_q == StWait) & mem_rvalid;
    if_rvalid = rsp & ~owner_q;
    d_rvalid  = rsp & owner_q;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid ? mem_rdata : '0;
  end

endmodule
